// File: rtl/gpr_pkg.sv
// Shared types for the GPR bank scheduler: bank image, reset constant, scheduler states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gpr_pkg;

  // Four-entry bank, indexed 1..4 to match the consumers' view of j.
  typedef shortint bank_t [1:4];

  // Contents restored by reset and by a CLEAR sweep.
  localparam bank_t GPR_RESET_IMAGE = '{16'sd1, 16'sd20, 16'sd2, 16'sd0};

  // IDLE arbitrates round-robin, BURST keeps one owner, CLEAR sweeps the image in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1.
// Latency: purely combinational.
// Backpressure: none; an all-zero request vector yields an all-zero grant.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] cand;

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      // ptr is always < N, so one conditional subtraction is enough to wrap.
      if (int'(ptr) + i >= N) begin
        cand = IW'(int'(ptr) + i - N);
      end else begin
        cand = IW'(int'(ptr) + i);
      end
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gpr_bank_sched.sv
// Write scheduler for the shared four-entry bank: round-robin writers, locked bursts, image restore.
// Latency: a write accepted on cycle N is visible on j at cycle N+1; ready is combinational.
// Backpressure: at most one ready per cycle; none while clearing or on the cycle that enters CLEAR.
module gpr_bank_sched
  import gpr_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][1:0]      req_idx,
  input  shortint                    req_data [N_REQ],
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       clr_start,
  output logic                       clr_busy,
  output bank_t                      j,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(N_REQ);

  sched_state_e  state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [1:0]    sweep_q, sweep_d;
  logic          clr_pend_q, clr_pend_d;
  bank_t         j_q, j_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] ready_c;
  logic             xfer;
  logic [IW-1:0]    xfer_id;

  // Next round-robin start after serving requester k.
  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] k);
    if (k == IW'(N_REQ - 1)) begin
      return '0;
    end
    return k + 1'b1;
  endfunction

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Next-state, ready generation and bank write selection.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_id_d = grant_id_q;
    bcnt_d     = bcnt_q;
    sweep_d    = sweep_q;
    clr_pend_d = clr_pend_q;
    j_d        = j_q;
    ready_c    = '0;
    xfer       = 1'b0;
    xfer_id    = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (clr_start || clr_pend_q) begin
          // Restore takes priority; nobody is ready on the entry cycle.
          state_d    = ST_CLEAR;
          clr_pend_d = 1'b0;
          sweep_d    = '0;
        end else if (|pick_gnt) begin
          ready_c = pick_gnt;
          xfer    = 1'b1;
          xfer_id = pick_idx;
          if (req_lock[pick_idx] && (MAX_BURST > 1)) begin
            state_d = ST_BURST;
            owner_d = pick_idx;
            bcnt_d  = 4'd1;
          end else begin
            rr_ptr_d = ptr_after(pick_idx);
          end
        end
      end

      ST_BURST: begin
        if (clr_start) begin
          clr_pend_d = 1'b1;
        end
        if (req_valid[owner_q]) begin
          ready_c[owner_q] = 1'b1;
          xfer             = 1'b1;
          xfer_id          = owner_q;
          bcnt_d           = bcnt_q + 4'd1;
          if (!req_lock[owner_q] || (bcnt_q + 4'd1 == 4'(MAX_BURST))) begin
            state_d  = ST_IDLE;
            rr_ptr_d = ptr_after(owner_q);
          end
        end else begin
          // Owner went quiet: release the bank to the others.
          state_d  = ST_IDLE;
          rr_ptr_d = ptr_after(owner_q);
        end
      end

      ST_CLEAR: begin
        if (clr_start) begin
          clr_pend_d = 1'b1;
        end
        for (int e = 1; e <= 4; e++) begin
          if (e == int'(sweep_q) + 1) begin
            j_d[e] = GPR_RESET_IMAGE[e];
          end
        end
        sweep_d = sweep_q + 2'd1;
        if (sweep_q == 2'd3) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (xfer) begin
      grant_id_d = xfer_id;
      for (int e = 1; e <= 4; e++) begin
        if (e == int'(req_idx[xfer_id]) + 1) begin
          j_d[e] = req_data[xfer_id];
        end
      end
    end
  end

  // State and bank registers; reset aborts any burst or sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_id_q <= '0;
      bcnt_q     <= '0;
      sweep_q    <= '0;
      clr_pend_q <= 1'b0;
      j_q        <= GPR_RESET_IMAGE;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_id_q <= grant_id_d;
      bcnt_q     <= bcnt_d;
      sweep_q    <= sweep_d;
      clr_pend_q <= clr_pend_d;
      j_q        <= j_d;
    end
  end

  assign req_ready = rst ? '0 : ready_c;
  assign clr_busy  = (state_q == ST_CLEAR);
  assign j         = j_q;
  assign grant_id  = grant_id_q;

endmodule

// File: doc/gpr_bank_sched.md
# gpr_bank_sched

Write scheduler for the four-entry `shortint` bank (`j[1:4]`, reset image 1, 20, 2, 0) shared by several requesters. It arbitrates write requests round-robin, supports short locked bursts for a single owner, and runs a sequential restore of the reset image on command. The bank sits between the stimulus requesters and the consumers that read `j`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `MAX_BURST`, 4, maximum transfers per locked burst (1..15)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  [N_REQ]  write request valid per requester
- `req_idx`  in  [N_REQ][1:0]  target entry, 0..3 maps to `j[1]..j[4]`
- `req_data`  in  shortint [N_REQ]  write data
- `req_lock`  in  [N_REQ]  requester asks to keep grant after this transfer
- `req_ready`  out  [N_REQ]  one-hot or zero; transfer = valid & ready
- `clr_start`  in  1  request restore of reset image
- `clr_busy`  out  1  restore in progress
- `j`  out  shortint [1:4]  bank contents
- `grant_id`  out  $clog2(N_REQ)  last granted requester

## Operation
- States: IDLE, BURST, CLEAR.
- IDLE: if `clr_start` or `clr_pend` → CLEAR, no ready that cycle. Else ready goes to the first valid requester at or after `rr_ptr` (wrapping). On transfer by k: write entry; if `req_lock[k]` and `MAX_BURST`>1 → BURST, owner=k, `bcnt`=1; else `rr_ptr`=k+1 mod N_REQ.
- BURST: only owner may be ready, and it is ready whenever it is valid. Each owner transfer increments `bcnt`. Return to IDLE with `rr_ptr`=owner+1 when:
  - the transfer has lock=0;
  - `bcnt` reaches `MAX_BURST`;
  - a cycle occurs with owner valid low.
- CLEAR: writes reset image to entries 1,2,3,4 on four consecutive cycles via a 2-bit sweep counter. `clr_busy`=1 and all ready=0 throughout. Then IDLE.
- `clr_start` seen outside IDLE sets `clr_pend`. `clr_pend` is served on the next IDLE cycle and cleared on CLEAR entry. Multiple pulses collapse to one restore.
- `grant_id` updates on every transfer and holds otherwise.

## Timing
- `req_ready` is combinational from state, `rr_ptr`, owner and `req_valid`. It never depends on `req_data`.
- Written data is visible on `j` the cycle after the transfer (1-cycle latency).
- One write per cycle maximum. Two requesters never see ready simultaneously.
- Reset values: `j`={1,20,2,0}, state IDLE, `rr_ptr`=0, `grant_id`=0, `clr_busy`=0, `clr_pend`=0, `req_ready`=0 during the reset cycle.
- `rst` during BURST or CLEAR aborts the operation immediately. A partially cleared bank is overwritten with the reset image anyway.
- A request held valid while waiting must keep `req_idx`/`req_data` stable. Data is sampled only on the transfer cycle.
- `rr_ptr` wraps from N_REQ-1 to 0.

## Structure
- Shared package `gpr_pkg`:
  - `bank_t` (shortint [1:4]);
  - constant `GPR_RESET_IMAGE` = '{1,20,2,0};
  - state enum `sched_state_e`.
- One sub-module, `rr_pick`: a combinational round-robin picker with inputs request vector and pointer, and outputs a one-hot grant and the encoded index. It is reusable by other schedulers in the codebase.

## Test plan
- Reset then idle: `j`={1,20,2,0}, all ready 0, `clr_busy`=0.
- Req 0,1,2 all valid with no lock, data 0x11/0x22/0x33 to entries 0/1/2. Grants follow the order 0,1,2 on consecutive cycles, and `j` becomes {0x11,0x22,0x33,0} by cycle 4.
- Req 1 with lock held for 6 transfers, MAX_BURST=4, and req 2 valid throughout. Req 1 gets exactly 4 transfers, then req 2 is granted, and `rr_ptr` lands at 2.
- `clr_start` pulsed during a burst. The burst completes, then CLEAR runs for 4 cycles with `clr_busy`=1 and no ready, leaving `j`={1,20,2,0}.
- `rst` asserted in the second CLEAR cycle. The next cycle shows reset values and no pending clear.
- Owner drops valid mid-burst for one cycle. FSM returns to IDLE and another valid requester is granted the following cycle.
